// File: rtl/dft_obs_bank.sv
// Multi-channel DFT observation bank: per-channel capture, hold,
// serial scan-out and a windowed MISR with a frozen-signature flag.
module dft_obs_bank #(
    parameter int WIDTH = 8,
    parameter int CHANNELS = 4,
    parameter logic [WIDTH*CHANNELS-1:0] POLY = 'h0000_00C5,
    parameter int WINDOW = 16
) (
    input  logic                      CP,
    input  logic                      CDN,
    input  logic [WIDTH*CHANNELS-1:0] D,
    input  logic [1:0]                MODE,
    input  logic [CHANNELS-1:0]       CH_EN,
    input  logic                      SI,
    output logic                      SO,
    output logic [WIDTH*CHANNELS-1:0] Q,
    output logic                      DONE,
    output logic                      BUSY
);

    localparam int N = WIDTH * CHANNELS;
    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] WIN = CW'(WINDOW);

    localparam logic [1:0] M_FUNC  = 2'b00;
    localparam logic [1:0] M_HOLD  = 2'b01;
    localparam logic [1:0] M_SHIFT = 2'b10;
    localparam logic [1:0] M_MISR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPACT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    logic [N-1:0]    q_n;
    logic [N-1:0]    mask;
    logic [N-1:0]    step;

    // Disabled channels contribute zeros to the signature.
    always_comb begin
        mask = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (CH_EN[c]) mask[c*WIDTH +: WIDTH] = D[c*WIDTH +: WIDTH];
        end
    end

    assign step = (Q << 1) ^ (Q[N-1] ? POLY : '0) ^ mask;
    assign SO   = Q[N-1];

    // State, window counter and status flags.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state <= S_IDLE;
            count <= '0;
            DONE  <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            DONE  <= (state_n == S_DONE);
            BUSY  <= (state_n == S_COMPACT);
        end
    end

    // Window sequencing: any non-MISR mode aborts back to IDLE.
    always_comb begin
        state_n = state;
        count_n = count;
        if (MODE != M_MISR) begin
            state_n = S_IDLE;
            count_n = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    count_n = CW'(1);
                    state_n = (WINDOW == 1) ? S_DONE : S_COMPACT;
                end
                S_COMPACT: begin
                    count_n = count + CW'(1);
                    state_n = (count_n == WIN) ? S_DONE : S_COMPACT;
                end
                S_DONE: begin
                    state_n = S_DONE;
                end
                default: begin
                    state_n = S_IDLE;
                    count_n = '0;
                end
            endcase
        end
    end

    // Next register contents for the selected mode.
    always_comb begin
        q_n = Q;
        unique case (MODE)
            M_FUNC: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (CH_EN[c]) q_n[c*WIDTH +: WIDTH] = D[c*WIDTH +: WIDTH];
                end
            end
            M_HOLD:  q_n = Q;
            M_SHIFT: q_n = {Q[N-2:0], SI};
            M_MISR:  if (state != S_DONE) q_n = step;
            default: q_n = Q;
        endcase
    end

    // Observation register.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) Q <= '0;
        else      Q <= q_n;
    end

endmodule

// File: tb/tb_dft_obs_bank.sv
// Directed bench for dft_obs_bank at N=8 (4x2), POLY=8'h1D,
// WINDOW=3 with hand-computed expected values.
module tb_dft_obs_bank;

    logic       CP = 1'b0;
    logic       CDN = 1'b0;
    logic [7:0] D = '0;
    logic [1:0] MODE = 2'b01;
    logic [1:0] CH_EN = 2'b00;
    logic       SI = 1'b0;
    logic       SO;
    logic [7:0] Q;
    logic       DONE;
    logic       BUSY;

    int n_pass = 0;
    int n_chk  = 0;

    dft_obs_bank #(
        .WIDTH(4), .CHANNELS(2), .POLY(8'h1D), .WINDOW(3)
    ) dut (
        .CP(CP), .CDN(CDN), .D(D), .MODE(MODE), .CH_EN(CH_EN),
        .SI(SI), .SO(SO), .Q(Q), .DONE(DONE), .BUSY(BUSY)
    );

    always #5 CP = ~CP;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        MODE = 2'b00; CH_EN = 2'b11; D = v;
        tick();
    endtask

    logic [7:0] si_seq = 8'b1000_0000;
    logic [7:0] so_exp = 8'b1000_0001;

    initial begin
        #12;
        chk("rst_q", Q, 0);
        chk("rst_so", SO, 0);
        chk("rst_done", DONE, 0);
        chk("rst_busy", BUSY, 0);
        @(negedge CP);
        CDN = 1'b1;

        // Functional capture, per-channel hold, global hold
        load(8'hA5);
        chk("func_load", Q, 8'hA5);
        CH_EN = 2'b01; D = 8'h3C; tick();
        chk("func_ch0", Q, 8'hAC);
        CH_EN = 2'b11; D = 8'h5F; tick();
        chk("func_all", Q, 8'h5F);
        MODE = 2'b01; D = 8'h00; tick();
        chk("hold_a", Q, 8'h5F);
        D = 8'hFF; tick();
        chk("hold_b", Q, 8'h5F);

        // Scan-out shift
        load(8'h81);
        MODE = 2'b10;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("so_%0d", i), SO, so_exp[7-i]);
            SI = si_seq[7-i];
            tick();
        end
        chk("shift_q", Q, 8'h80);

        // MISR window from zero seed
        load(8'h00);
        MODE = 2'b11; D = 8'h01; tick();
        chk("misr1_q", Q, 8'h01);
        chk("misr1_busy", BUSY, 1);
        chk("misr1_done", DONE, 0);
        D = 8'h00; tick();
        chk("misr2_q", Q, 8'h02);
        chk("misr2_busy", BUSY, 1);
        D = 8'h80; tick();
        chk("misr3_q", Q, 8'h84);
        chk("misr3_done", DONE, 1);
        chk("misr3_busy", BUSY, 0);
        D = 8'hFF; tick();
        chk("frozen_q", Q, 8'h84);
        chk("frozen_done", DONE, 1);

        // Masked channel with polynomial feedback
        load(8'h80);
        MODE = 2'b11; CH_EN = 2'b01; D = 8'hF0; tick();
        chk("mask_poly", Q, 8'h1D);

        // Reset mid-window
        load(8'h00);
        MODE = 2'b11; D = 8'h01; tick();
        D = 8'h00; tick();
        chk("pre_rst_q", Q, 8'h02);
        chk("pre_rst_busy", BUSY, 1);
        #1 CDN = 1'b0;
        #1;
        chk("arst_q", Q, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_done", DONE, 0);
        chk("arst_so", SO, 0);
        D = 8'h01;
        @(negedge CP);
        CDN = 1'b1;
        tick();
        chk("rw1_q", Q, 8'h01);
        chk("rw1_busy", BUSY, 1);
        D = 8'h00; tick();
        chk("rw2_done", DONE, 0);
        tick();
        chk("rw3_q", Q, 8'h04);
        chk("rw3_done", DONE, 1);

        // Leave DONE through FUNC, then a fresh window
        MODE = 2'b00; CH_EN = 2'b00; tick();
        chk("exit_done", DONE, 0);
        chk("exit_busy", BUSY, 0);
        chk("exit_q", Q, 8'h04);
        MODE = 2'b11; CH_EN = 2'b11; D = 8'h00; tick();
        chk("nw1_q", Q, 8'h08);
        chk("nw1_busy", BUSY, 1);
        tick();
        chk("nw2_q", Q, 8'h10);
        chk("nw2_done", DONE, 0);
        tick();
        chk("nw3_q", Q, 8'h20);
        chk("nw3_done", DONE, 1);
        chk("nw3_busy", BUSY, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dft_obs_bank.md
Name: dft_obs_bank

Overview:
- Parametrised, multi-channel DFT observation register bank.
- Generalises the single-bit hold/observe cell to CHANNELS x WIDTH bits.
- Modes:
  - functional capture, with per-channel hold
  - global hold
  - serial scan-out shift
  - windowed MISR signature compaction, with a DONE flag
- Sits between functional logic under observation and the test access chain.

Parameters:
- WIDTH, 8: bits per channel.
- CHANNELS, 4: number of channels; total N = WIDTH*CHANNELS.
- POLY, 32'h0000_00C5: MISR feedback polynomial, N bits, applied when the register MSB is 1.
- WINDOW, 16: MISR compaction cycles before the signature freezes; must be >= 1.

Ports:
- CP      input   1         clock, rising edge
- CDN     input   1         asynchronous active-low reset
- D       input   N         observed functional data; channel c = D[c*WIDTH +: WIDTH]
- MODE    input   2         00 FUNC, 01 HOLD, 10 SHIFT, 11 MISR
- CH_EN   input   CHANNELS  per-channel capture enable (FUNC) / data mask (MISR)
- SI      input   1         scan-in
- SO      output  1         scan-out = Q[N-1]
- Q       output  N         observation register contents
- DONE    output  1         MISR window complete; signature frozen
- BUSY    output  1         MISR compaction in progress

Behaviour:
- One clock domain, CP.
- CDN low, asynchronously: Q=0, SO=0, state IDLE, count=0, DONE=0, BUSY=0. Release is synchronous to the next CP edge.
- All outputs are registered. SO is Q[N-1], taken directly from the register.
- Reset asserted mid-window aborts the window. After reset, a new MISR entry starts a fresh window.
- FUNC (00):
  - Channel c with CH_EN[c]=1: Q[c] <= D[c].
  - Channel c with CH_EN[c]=0: Q[c] holds.
  - One-cycle latency.
- HOLD (01): Q holds entirely. Overrides CH_EN.
- SHIFT (10):
  - Q <= {Q[N-2:0], SI}. CH_EN is ignored.
  - After N shifts the original Q has fully appeared on SO, MSB first.
- MISR (11):
  - Masked input M = D with each disabled channel's bits forced to 0.
  - Compaction step: Q <= (Q<<1) ^ (Q[N-1] ? POLY : 0) ^ M.
- MISR FSM, states IDLE / COMPACT / DONE:
  - IDLE & MODE=11: compaction step, count<=1. If WINDOW==1, go to DONE; else go to COMPACT.
  - COMPACT & MODE=11: compaction step, count<=count+1. When the new count == WINDOW, go to DONE.
  - DONE & MODE=11: Q holds (signature frozen), count holds.
  - Any state & MODE!=11: go to IDLE, count<=0. The current MODE's action applies on that same edge.
  - BUSY=1 in COMPACT. DONE=1 in DONE. Both are registered with the state.
- Seeding: Q is not cleared on MISR entry. The current Q is the seed, so FUNC/HOLD can preload it.
- Switching to SHIFT from DONE is allowed; the signature is unloaded via SO.
- Exactly WINDOW compaction edges occur per window. Re-entering MISR from IDLE restarts the window.
- Count register width: clog2(WINDOW+1).

Test Plan:
1. Setup: N=8 (WIDTH=4, CHANNELS=2), POLY=8'h1D, WINDOW=3.
   - Stimulus: FUNC, CH_EN=2'b01, Q=8'hA5, D=8'h3C.
   - Required: Q=8'hAC one cycle later.
   - Then CH_EN=2'b11, D=8'h5F -> Q=8'h5F.
   - Then HOLD with D toggling -> Q stays 8'h5F.
2. Q=8'h81, SHIFT, SI=1,0,0,0,0,0,0,0 over 8 cycles.
   - Required: SO sequence 1,0,0,0,0,0,0,1 (sampled before each edge); final Q=8'h80.
3. Preload Q=8'h00, then MISR with D=8'h01, 8'h00, 8'h80.
   - Required: Q=8'h01, 8'h02, 8'h84.
   - BUSY=1 after the 1st and 2nd edges; DONE=1, BUSY=0 after the 3rd edge.
   - Further D changes leave Q=8'h84.
4. Q=8'h80, MISR, CH_EN=2'b01, D=8'hF0 (masked to 0).
   - Required: first step Q=8'h1D.
5. Reset mid-window: pull CDN low after 2 compaction edges.
   - Required: Q, DONE, BUSY, SO go to 0 immediately, without waiting for a clock edge.
   - After release, MISR from Q=0 with D=1,0,0 -> DONE after exactly 3 edges.
6. In DONE, switch MODE to FUNC for 1 cycle, then back to MISR.
   - Required: DONE=0 and BUSY=0 after the FUNC edge; a new 3-edge window completes with DONE=1.
